// File: rtl/alu_core_if.sv
// Operand/control/result bundle between an ALU client and alu_core.
// The master drives operands and control; the slave returns registered RESULT/Flags.
interface alu_core_if;
  logic        EN;
  logic [15:0] A;
  logic [15:0] B;
  logic [2:0]  ALUControl;
  logic        EQ;
  logic [15:0] RESULT;
  logic [4:0]  Flags;

  modport master (
    output EN, A, B, ALUControl, EQ,
    input  RESULT, Flags
  );

  modport slave (
    input  EN, A, B, ALUControl, EQ,
    output RESULT, Flags
  );
endinterface

// File: rtl/alu_core.sv
// 16-bit ALU with shared adder, equality comparator and flag logic feeding
// registered RESULT and Flags {E,N,Z,C,V}; one-cycle latency, ops 110/111 are no-ops.
module alu_core (
  input  logic       clk,
  input  logic       rst_n,
  alu_core_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_INC  = 3'b001,
    OP_CMP  = 3'b010,
    OP_LDST = 3'b011,
    OP_MOV  = 3'b100,
    OP_BNQ  = 3'b101,
    OP_NOP6 = 3'b110,
    OP_NOP7 = 3'b111
  } op_e;

  localparam int FLAG_E = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  op_e         op;
  logic [15:0] add_b;
  logic        add_cin;
  logic [16:0] add_sum;
  logic        add_c;
  logic        add_v;
  logic        a_eq_b;
  logic        load_en;
  logic [15:0] result_d;
  logic [15:0] result_q;
  logic [4:0]  flags_d;
  logic [4:0]  flags_q;

  assign op = op_e'(bus.ALUControl);

  // One adder serves ADD, INC and CMP; subtraction is A + ~B + 1.
  always_comb begin
    add_b   = bus.B;
    add_cin = 1'b0;
    case (op)
      OP_INC:  add_b = 16'h0001;
      OP_CMP: begin
        add_b   = ~bus.B;
        add_cin = 1'b1;
      end
      default: add_b = bus.B;
    endcase
  end

  assign add_sum = {1'b0, bus.A} + {1'b0, add_b} + {16'b0, add_cin};
  assign add_c   = add_sum[16];
  // With add_b = ~B this reduces to the subtract rule A[15]!=B[15].
  assign add_v   = (bus.A[15] == add_b[15]) && (add_sum[15] != bus.A[15]);
  assign a_eq_b  = (bus.A == bus.B);

  assign load_en = bus.EN && (op != OP_NOP6) && (op != OP_NOP7);

  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    case (op)
      OP_ADD, OP_INC, OP_CMP: begin
        result_d         = add_sum[15:0];
        flags_d[FLAG_C]  = add_c;
        flags_d[FLAG_V]  = add_v;
      end
      OP_LDST: begin
        result_d         = bus.A;
        flags_d[FLAG_C]  = 1'b0;
        flags_d[FLAG_V]  = 1'b0;
      end
      OP_MOV: begin
        result_d         = bus.B;
        flags_d[FLAG_C]  = 1'b0;
        flags_d[FLAG_V]  = 1'b0;
      end
      OP_BNQ: begin
        result_d         = {15'b0, ~bus.EQ};
        flags_d[FLAG_C]  = 1'b0;
        flags_d[FLAG_V]  = 1'b0;
      end
      default: begin
        result_d = result_q;
        flags_d  = flags_q;
      end
    endcase
    if (op == OP_CMP) begin
      flags_d[FLAG_E] = a_eq_b;
    end
    if ((op != OP_NOP6) && (op != OP_NOP7)) begin
      flags_d[FLAG_N] = result_d[15];
      flags_d[FLAG_Z] = (result_d == 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 16'h0000;
      flags_q  <= 5'b00000;
    end else if (load_en) begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.RESULT = result_q;
  assign bus.Flags  = flags_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: hand-computed RESULT/Flags after each step,
// including wrap-around, E hold, no-op codes, EN=0 hold and async reset.
module tb_alu_core;

  logic clk;
  logic rst_n;
  int   n_compared;
  int   n_mismatched;

  alu_core_if bus ();

  alu_core u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] exp_res, input logic [4:0] exp_flags);
    n_compared++;
    assert (bus.RESULT === exp_res) else begin
      n_mismatched++;
      $error("FAIL %s RESULT observed=%h expected=%h", tag, bus.RESULT, exp_res);
    end
    n_compared++;
    assert (bus.Flags === exp_flags) else begin
      n_mismatched++;
      $error("FAIL %s Flags observed=%b expected=%b", tag, bus.Flags, exp_flags);
    end
    $display("step %-10s RESULT=%h Flags(ENZCV)=%b", tag, bus.RESULT, bus.Flags);
  endtask

  task automatic step(input logic en, input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic eq);
    bus.EN         = en;
    bus.ALUControl = op;
    bus.A          = a;
    bus.B          = b;
    bus.EQ         = eq;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_compared     = 0;
    n_mismatched   = 0;
    rst_n          = 1'b0;
    bus.EN         = 1'b0;
    bus.ALUControl = 3'b000;
    bus.A          = 16'h0000;
    bus.B          = 16'h0000;
    bus.EQ         = 1'b0;

    #2;
    check("reset", 16'h0000, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;

    // Flags order {E,N,Z,C,V}
    step(1'b1, 3'b000, 16'h7FFF, 16'h0001, 1'b0);
    check("add_ovf", 16'h8000, 5'b01001);
    step(1'b1, 3'b001, 16'hFFFF, 16'h1234, 1'b0);
    check("inc_wrap", 16'h0000, 5'b00110);
    step(1'b1, 3'b010, 16'h1234, 16'h1234, 1'b0);
    check("cmp_eq", 16'h0000, 5'b10110);
    step(1'b1, 3'b000, 16'h0001, 16'h0002, 1'b0);
    check("add_ehold", 16'h0003, 5'b10000);
    step(1'b1, 3'b010, 16'h0001, 16'h0002, 1'b0);
    check("cmp_lt", 16'hFFFF, 5'b01000);
    step(1'b1, 3'b100, 16'h5555, 16'h0000, 1'b0);
    check("mov_zero", 16'h0000, 5'b00100);
    step(1'b1, 3'b101, 16'h0000, 16'h0000, 1'b0);
    check("bnq_taken", 16'h0001, 5'b00000);
    step(1'b1, 3'b110, 16'hFFFF, 16'hFFFF, 1'b1);
    check("nop110", 16'h0001, 5'b00000);
    step(1'b0, 3'b000, 16'h0005, 16'h0005, 1'b0);
    check("en0_hold", 16'h0001, 5'b00000);
    step(1'b1, 3'b000, 16'hFFFF, 16'h0001, 1'b0);
    check("add_wrap", 16'h0000, 5'b00110);
    step(1'b1, 3'b010, 16'h8000, 16'h0001, 1'b0);
    check("cmp_ovf", 16'h7FFF, 5'b00011);
    step(1'b1, 3'b010, 16'h0005, 16'h0005, 1'b0);
    check("cmp_eq2", 16'h0000, 5'b10110);
    step(1'b1, 3'b011, 16'hABCD, 16'h0001, 1'b0);
    check("ldst", 16'hABCD, 5'b11000);
    step(1'b1, 3'b101, 16'h0000, 16'h0000, 1'b1);
    check("bnq_nt", 16'h0000, 5'b10100);
    step(1'b1, 3'b111, 16'h1111, 16'h2222, 1'b0);
    check("nop111", 16'h0000, 5'b10100);
    step(1'b1, 3'b000, 16'h8000, 16'h8000, 1'b0);
    check("add_cv", 16'h0000, 5'b10111);
    step(1'b1, 3'b100, 16'h0000, 16'h8000, 1'b0);
    check("mov_neg", 16'h8000, 5'b11000);

    // Reset between edges with an update pending: outputs clear at once.
    bus.EN         = 1'b1;
    bus.ALUControl = 3'b000;
    bus.A          = 16'h0001;
    bus.B          = 16'h0001;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async", 16'h0000, 5'b00000);
    @(posedge clk);
    #1;
    check("rst_held", 16'h0000, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'b000, 16'h0001, 16'h0001, 1'b0);
    check("post_rst", 16'h0002, 5'b00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 16 bits.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 EN  input  1  update enable; when 1 the RESULT and Flags registers load on the clock edge.
REQ-006 A  input  16  operand A.
REQ-007 B  input  16  operand B.
REQ-008 ALUControl  input  3  operation select.
REQ-009 EQ  input  1  external equal status used by the BNQ operation.
REQ-010 RESULT  output  16  registered result.
REQ-011 Flags  output  5  registered flags; bit4 E, bit3 N, bit2 Z, bit1 C, bit0 V.

Function
REQ-012 Sub-blocks: a 16-bit adder with carry-in and carry-out, an equality/magnitude comparator, and flag logic, all combinational, feeding the output registers.
REQ-013 Latency SHALL be 1 cycle: inputs sampled at edge k with EN=1 appear on RESULT/Flags after edge k.
REQ-014 With EN=0, RESULT and Flags SHALL hold their values.
REQ-015 Operation 000 ADD: RESULT = (A+B) mod 2^16.
  - C = carry out of bit 15.
  - V = (A[15]==B[15]) && (sum[15]!=A[15]).
REQ-016 Operation 001 INC: RESULT = (A+1) mod 2^16.
  - C and V computed as ADD with B=16'h0001.
REQ-017 Operation 010 CMP: RESULT = (A-B) mod 2^16, computed as A + ~B + 1.
  - C = 1 when A >= B unsigned (no borrow).
  - V = (A[15]!=B[15]) && (diff[15]!=A[15]).
REQ-018 Operation 011 LOAD/STORE: RESULT = A (address pass-through).
REQ-019 Operation 100 MOV: RESULT = B.
REQ-020 Operation 101 BNQ: RESULT = {15'b0, ~EQ}; bit0 = 1 means branch taken.
REQ-021 Operations 110 and 111 SHALL be no-ops: RESULT and Flags hold, even with EN=1.
REQ-022 N SHALL equal the new RESULT bit15 for operations 000-101.
REQ-023 Z SHALL equal (new RESULT == 0) for operations 000-101.
REQ-024 C and V SHALL be cleared to 0 for operations 011, 100 and 101.
REQ-025 E SHALL be updated only by CMP, where E = (A==B); all other operations hold E.
REQ-026 Wrap-around: 16'hFFFF+1 SHALL give RESULT 0 with Z=1 and C=1; overflow is never saturated.
REQ-027 All outputs SHALL be driven from registers; there is no combinational input-to-output path.

Reset
REQ-028 When rst_n=0, RESULT SHALL be 16'h0000 and Flags SHALL be 5'b00000, immediately and independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard the pending update.
REQ-030 After rst_n deasserts, the first EN=1 edge SHALL perform a normal update.

Verification
REQ-031 ADD A=16'h7FFF, B=16'h0001 -> next cycle RESULT=16'h8000, Flags N=1, Z=0, C=0, V=1, E unchanged.
REQ-032 INC A=16'hFFFF -> RESULT=16'h0000, Z=1, C=1, V=0, N=0.
REQ-033 CMP A=B=16'h1234 -> RESULT=16'h0000, E=1, Z=1, C=1, V=0; a following ADD 1+2 -> RESULT=16'h0003 with E still 1.
REQ-034 CMP A=16'h0001, B=16'h0002 -> RESULT=16'hFFFF, E=0, N=1, C=0, V=0.
REQ-035 MOV B=16'h0000 -> RESULT=0, Z=1, C=V=0; BNQ EQ=0 -> RESULT=16'h0001; op 110 -> outputs hold.
REQ-036 EN=0 with any op -> outputs hold; rst_n pulsed low between edges -> RESULT=0, Flags=0 immediately.
